sprite_memory_loader: RTL and testbench



---
 rtl/sprite_mem_pkg.sv | 25 ++
 rtl/sprite_clear_counter.sv | 36 +++
 rtl/sprite_memory_loader.sv | 130 +++++++++++++
 tb/tb_sprite_memory_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_mem_pkg.sv
// Shared sprite colour memory constants, loader state type and wrap helper.
// Used by the loader, the sprite memory and the pixel-fetch stage.
package sprite_mem_pkg;

  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 9;
  localparam int DEPTH      = 16384;

  localparam logic [DATA_WIDTH-1:0] CLEAR_COLOR = 9'h000;

  typedef enum logic {
    CLEAR,
    READY
  } loader_state_t;

  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(
    input logic [ADDR_WIDTH-1:0] x,
    input int unsigned           depth
  );
    logic [31:0] v;
    v = 32'(x) + 32'd1;
    return (v >= depth) ? '0 : v[ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sprite_clear_counter.sv
// Modulo-DEPTH address counter: enable, synchronous clear, load-plus-one
// and terminal-count flag.
module sprite_clear_counter
  import sprite_mem_pkg::*;
#(
  parameter int unsigned DEPTH = sprite_mem_pkg::DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_val,
  output logic [ADDR_WIDTH-1:0] o_q,
  output logic                  o_tc
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST =
    ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] r_q;

  // Load stores the location after i_load_val, ready for the next use.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= wrap_inc(i_load_val, DEPTH);
    end else if (i_en) begin
      r_q <= wrap_inc(r_q, DEPTH);
    end
  end

  assign o_q  = r_q;
  assign o_tc = (r_q == LP_LAST);

endmodule

// File: rtl/sprite_memory_loader.sv
// Sprite colour memory write front end: clear sweep, then processor writes.
// Optional SPRITE_MEMORY_LOADER_AUTOINC_EN adds wr_auto and a write pointer.
module sprite_memory_loader
  import sprite_mem_pkg::*;
#(
  parameter int unsigned            DEPTH       = sprite_mem_pkg::DEPTH,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_COLOR = sprite_mem_pkg::CLEAR_COLOR
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0] wr_data,
`ifdef SPRITE_MEMORY_LOADER_AUTOINC_EN
  input  logic                  wr_auto,
`endif
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  reset_done,
  output logic                  wr_error
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH =
    (ADDR_WIDTH + 1)'(DEPTH);

  loader_state_t r_state;
  loader_state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] w_cnt;
  logic                  w_cnt_tc;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_sweep;
  logic                  w_accept;
  logic                  w_in_range;

  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_mem_wren;
  logic                  r_reset_done;
  logic                  r_wr_error;

  assign wr_ready   = (r_state == READY) && !clear_req;
  assign w_accept   = wr_valid && wr_ready;
  // A clear request in READY issues the first sweep write immediately.
  assign w_sweep    = (r_state == CLEAR) ||
                      ((r_state == READY) && clear_req);
  assign w_in_range = ({1'b0, w_addr} < LP_DEPTH);

  sprite_clear_counter #(
    .DEPTH (DEPTH)
  ) u_clear_cnt (
    .i_clk      (clock),
    .i_clr      (reset),
    .i_en       (w_sweep),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_q        (w_cnt),
    .o_tc       (w_cnt_tc)
  );

`ifdef SPRITE_MEMORY_LOADER_AUTOINC_EN
  logic [ADDR_WIDTH-1:0] w_ptr;

  sprite_clear_counter #(
    .DEPTH (DEPTH)
  ) u_ptr_cnt (
    .i_clk      (clock),
    .i_clr      (reset || ((r_state == CLEAR) && w_cnt_tc)),
    .i_en       (w_accept && wr_auto),
    .i_load     (w_accept && !wr_auto),
    .i_load_val (wr_address),
    .o_q        (w_ptr),
    .o_tc       ()
  );

  assign w_addr = wr_auto ? w_ptr : wr_address;
`else
  assign w_addr = wr_address;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CLEAR:   if (w_cnt_tc)  w_state_nxt = READY;
      READY:   if (clear_req) w_state_nxt = CLEAR;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_wren    <= 1'b0;
      r_reset_done  <= 1'b0;
      r_wr_error    <= 1'b0;
    end else begin
      r_reset_done <= (w_state_nxt == READY);
      r_wr_error   <= w_accept && !w_in_range;
      r_mem_wren   <= 1'b0;
      if (w_sweep) begin
        r_mem_wren    <= 1'b1;
        r_mem_address <= w_cnt;
        r_mem_data    <= CLEAR_COLOR;
      end else if (w_accept && w_in_range) begin
        r_mem_wren    <= 1'b1;
        r_mem_address <= w_addr;
        r_mem_data    <= wr_data;
      end
    end
  end

  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_wren    = r_mem_wren;
  assign reset_done  = r_reset_done;
  assign wr_error    = r_wr_error;

endmodule

// File: tb/tb_sprite_memory_loader.sv
// Directed bench: full-depth loader (A) and a DEPTH=10000 loader (B).
// Build with SPRITE_MEMORY_LOADER_AUTOINC_EN to add the pointer checks.
module tb_sprite_memory_loader;
  import sprite_mem_pkg::*;

  localparam int DA = 16384;
  localparam int DB = 10000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic                  a_clr, a_valid, a_ready, a_auto;
  logic [ADDR_WIDTH-1:0] a_waddr, a_maddr;
  logic [DATA_WIDTH-1:0] a_wdata, a_mdata;
  logic                  a_wren, a_done, a_err;

  logic                  b_clr, b_valid, b_ready, b_auto;
  logic [ADDR_WIDTH-1:0] b_waddr, b_maddr;
  logic [DATA_WIDTH-1:0] b_wdata, b_mdata;
  logic                  b_wren, b_done, b_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  sprite_memory_loader u_dut_a (
    .clock       (clock),
    .reset       (reset),
    .clear_req   (a_clr),
    .wr_valid    (a_valid),
    .wr_ready    (a_ready),
    .wr_address  (a_waddr),
    .wr_data     (a_wdata),
`ifdef SPRITE_MEMORY_LOADER_AUTOINC_EN
    .wr_auto     (a_auto),
`endif
    .mem_address (a_maddr),
    .mem_data    (a_mdata),
    .mem_wren    (a_wren),
    .reset_done  (a_done),
    .wr_error    (a_err)
  );

  sprite_memory_loader #(
    .DEPTH (DB)
  ) u_dut_b (
    .clock       (clock),
    .reset       (reset),
    .clear_req   (b_clr),
    .wr_valid    (b_valid),
    .wr_ready    (b_ready),
    .wr_address  (b_waddr),
    .wr_data     (b_wdata),
`ifdef SPRITE_MEMORY_LOADER_AUTOINC_EN
    .wr_auto     (b_auto),
`endif
    .mem_address (b_maddr),
    .mem_data    (b_mdata),
    .mem_wren    (b_wren),
    .reset_done  (b_done),
    .wr_error    (b_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expects the next rising edge to issue clear address 0 on loader A.
  task automatic sweep(input string tag);
    int bad = 0;
    for (int i = 0; i < DA; i++) begin
      @(negedge clock);
      a_clr = 1'b0;
      if (a_wren !== 1'b1 || a_maddr !== 14'(i) ||
          a_mdata !== 9'h000 ||
          a_ready !== (i == DA - 1) ||
          a_done !== (i == DA - 1) || a_err !== 1'b0)
        bad++;
    end
    check({tag, "_bad_cycles"}, bad, 0);
    check({tag, "_done"}, a_done, 1);
    check({tag, "_ready"}, a_ready, 1);
  endtask

  initial begin
    int bad;
    a_clr = 0; a_valid = 0; a_auto = 0; a_waddr = '0; a_wdata = '0;
    b_clr = 0; b_valid = 0; b_auto = 0; b_waddr = '0; b_wdata = '0;

    repeat (3) @(negedge clock);
    check("rst_wren", a_wren, 0);
    check("rst_addr", a_maddr, 0);
    check("rst_data", a_mdata, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    check("rst_ready", a_ready, 0);
    check("rst_b_done", b_done, 0);
    reset = 1'b0;

    sweep("sweep0");

    a_valid = 1; a_waddr = 14'h0005; a_wdata = 9'h1FF;
    @(negedge clock);
    check("w0_wren", a_wren, 1);
    check("w0_addr", a_maddr, 14'h0005);
    check("w0_data", a_mdata, 9'h1FF);
    a_waddr = 14'h0006; a_wdata = 9'h0A3;
    @(negedge clock);
    check("w1_wren", a_wren, 1);
    check("w1_addr", a_maddr, 14'h0006);
    check("w1_data", a_mdata, 9'h0A3);
    a_waddr = 14'h3FFF; a_wdata = 9'h001;
    @(negedge clock);
    check("w2_wren", a_wren, 1);
    check("w2_addr", a_maddr, 14'h3FFF);
    check("w2_data", a_mdata, 9'h001);
    check("w2_err", a_err, 0);
    a_valid = 0;
    @(negedge clock);
    check("idle_wren", a_wren, 0);
    check("idle_addr", a_maddr, 14'h3FFF);
    check("idle_data", a_mdata, 9'h001);

    a_clr = 1; a_valid = 1; a_waddr = 14'h0100; a_wdata = 9'h1FF;
    #1;
    check("cr_ready", a_ready, 0);
    sweep("sweep1");
    @(negedge clock);
    check("held_wren", a_wren, 1);
    check("held_addr", a_maddr, 14'h0100);
    check("held_data", a_mdata, 9'h1FF);
    a_valid = 0;
    @(negedge clock);
    check("held_idle", a_wren, 0);

    a_clr = 1;
    bad = 0;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clock);
      a_clr = 0;
      if (a_wren !== 1'b1 || a_maddr !== 14'(i)) bad++;
    end
    check("part_bad_cycles", bad, 0);
    reset = 1;
    @(negedge clock);
    check("mr_wren", a_wren, 0);
    check("mr_addr", a_maddr, 0);
    check("mr_done", a_done, 0);
    reset = 0;
    sweep("sweep2");

    check("b_done", b_done, 1);
    b_valid = 1; b_waddr = 14'd12000; b_wdata = 9'h055;
    #1;
    check("oor_ready", b_ready, 1);
    @(negedge clock);
    check("oor_wren", b_wren, 0);
    check("oor_err", b_err, 1);
    b_waddr = 14'd9999; b_wdata = 9'h0AB;
    @(negedge clock);
    check("edge_wren", b_wren, 1);
    check("edge_addr", b_maddr, 14'd9999);
    check("edge_data", b_mdata, 9'h0AB);
    check("edge_err", b_err, 0);
    b_valid = 0;
    @(negedge clock);
    check("b_idle_wren", b_wren, 0);
    check("b_idle_err", b_err, 0);

`ifdef SPRITE_MEMORY_LOADER_AUTOINC_EN
    begin
      logic [ADDR_WIDTH-1:0] exp_a [3];
      exp_a[0] = 14'd9999; exp_a[1] = 14'd0; exp_a[2] = 14'd1;
      b_valid = 1; b_auto = 0; b_waddr = 14'd9998; b_wdata = 9'h011;
      @(negedge clock);
      check("ai0_wren", b_wren, 1);
      check("ai0_addr", b_maddr, 14'd9998);
      b_auto = 1; b_waddr = 14'd5;
      for (int k = 0; k < 3; k++) begin
        b_wdata = 9'(k + 2);
        @(negedge clock);
        check("ai_wren", b_wren, 1);
        check("ai_addr", b_maddr, exp_a[k]);
        check("ai_data", b_mdata, 9'(k + 2));
      end
      b_valid = 0; b_auto = 0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
